// File: rtl/calc2_arb_pkg.sv
// Shared types and helpers for the calc2 request arbiter.
// Contents: command/response encodings, capture FSM states, the captured
// request record, and helpers that pack/unpack the ALU id {port, tag}.
package calc2_arb_pkg;

  localparam int NPORT   = 4;   // fixed: the top-level port list is written out per port
  localparam int DW      = 32;
  localparam int MAX_OUT = 4;

  typedef enum logic [3:0] {
    CMD_IDLE = 4'd0,
    CMD_ADD  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_SHL  = 4'd5,
    CMD_SHR  = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2,
    RESP_BUSY = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_OP2  = 2'd1,
    CAP_PEND = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic [3:0]    cmd;
    logic [1:0]    tag;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
  } req_t;

  function automatic logic [3:0] make_id(input logic [1:0] port, input logic [1:0] tag);
    return {port, tag};
  endfunction

  function automatic logic [1:0] id_port(input logic [3:0] id);
    return id[3:2];
  endfunction

  function automatic logic [1:0] id_tag(input logic [3:0] id);
    return id[1:0];
  endfunction

  function automatic logic cmd_valid(input logic [3:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_SHL) || (c == CMD_SHR);
  endfunction

endpackage

// File: rtl/calc2_port_capture.sv
// Per-port request capture for the calc2 arbiter.
// Collects a two-cycle request (cmd/tag/op1, then op2) into a one-entry
// slot, holds it pending until the arbiter issues it, and keeps one
// reject flag (busy or invalid command) until the top drains it.
// Ports:
//   c_clk, reset_n   clock, async active-low reset
//   cmd_in/data_in/tag_in  requester pins for this port
//   issue_i          ALU handshake granted to this port this cycle
//   rej_take_i       top emits the reject flag this cycle
//   pend_o, req_o    slot full / slot contents
//   rej_valid_o, rej_resp_o, rej_tag_o  queued reject
//
// state    | meaning
// CAP_IDLE | slot empty, waiting for a command
// CAP_OP2  | cmd/op1 latched, this cycle carries op2
// CAP_PEND | slot full, waiting for an issue handshake
module calc2_port_capture
  import calc2_arb_pkg::*;
(
  input  logic          c_clk,
  input  logic          reset_n,
  input  logic [3:0]    cmd_in,
  input  logic [DW-1:0] data_in,
  input  logic [1:0]    tag_in,
  input  logic          issue_i,
  input  logic          rej_take_i,
  output logic          pend_o,
  output req_t          req_o,
  output logic          rej_valid_o,
  output logic [1:0]    rej_resp_o,
  output logic [1:0]    rej_tag_o
);

  cap_state_e state_q, state_d;
  req_t       slot_q, slot_d;
  logic       bad_q, bad_d;
  logic       rej_q, rej_d;
  logic [1:0] rej_resp_q, rej_resp_d;
  logic [1:0] rej_tag_q, rej_tag_d;
  logic       capture;
  logic       rej_set;
  logic [1:0] rej_set_resp;
  logic [1:0] rej_set_tag;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    bad_d        = bad_q;
    rej_set      = 1'b0;
    rej_set_resp = RESP_NONE;
    rej_set_tag  = tag_in;
    // A new command is taken from IDLE, or from PEND when the slot frees this cycle.
    capture = (cmd_in != 4'd0) &&
              ((state_q == CAP_IDLE) || ((state_q == CAP_PEND) && issue_i));

    case (state_q)
      CAP_IDLE: if (capture) state_d = CAP_OP2;
      CAP_OP2: begin
        slot_d.op2 = data_in;
        if (bad_q) begin
          // invalid command: op2 cycle consumed, never issued
          rej_set      = 1'b1;
          rej_set_resp = RESP_ERR;
          rej_set_tag  = slot_q.tag;
          state_d      = CAP_IDLE;
        end else begin
          state_d = CAP_PEND;
        end
      end
      CAP_PEND: begin
        if (issue_i) begin
          state_d = capture ? CAP_OP2 : CAP_IDLE;
        end else if (cmd_in != 4'd0) begin
          rej_set      = 1'b1;
          rej_set_resp = RESP_BUSY;
        end
      end
      default: state_d = CAP_IDLE;
    endcase

    if (capture) begin
      slot_d.cmd = cmd_in;
      slot_d.tag = tag_in;
      slot_d.op1 = data_in;
      slot_d.op2 = '0;
      bad_d      = !cmd_valid(cmd_in);
    end

    rej_d      = rej_q && !rej_take_i;
    rej_resp_d = rej_resp_q;
    rej_tag_d  = rej_tag_q;
    // Only one reject is remembered; a second one while the flag is held is dropped.
    if (rej_set && !rej_d) begin
      rej_d      = 1'b1;
      rej_resp_d = rej_set_resp;
      rej_tag_d  = rej_set_tag;
    end
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CAP_IDLE;
      slot_q     <= '0;
      bad_q      <= 1'b0;
      rej_q      <= 1'b0;
      rej_resp_q <= '0;
      rej_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      bad_q      <= bad_d;
      rej_q      <= rej_d;
      rej_resp_q <= rej_resp_d;
      rej_tag_q  <= rej_tag_d;
    end
  end

  assign pend_o      = (state_q == CAP_PEND);
  assign req_o       = slot_q;
  assign rej_valid_o = rej_q;
  assign rej_resp_o  = rej_resp_q;
  assign rej_tag_o   = rej_tag_q;

endmodule

// File: rtl/calc2_req_arbiter.sv
// Front-end scheduler sharing one calc2 ALU pipe among four requester ports.
// Per-port capture, round-robin issue onto a valid/ready ALU interface with
// an in-flight limit, and registered routing of ALU results and rejects back
// to the originating port.
// Ports:
//   c_clk, reset_n                       clock, async active-low reset
//   reqN_cmd_in/data_in/tag_in (N=1..4)  requester pins
//   out_respN/out_dataN/out_tagN         one-cycle completion per port
//   alu_valid/ready/cmd/op1/op2/id       issue interface, id = {port, tag}
//   alu_rsp_valid/id/resp/data           ALU result return
module calc2_req_arbiter
  import calc2_arb_pkg::*;
(
  input  logic          c_clk,
  input  logic          reset_n,
  input  logic [3:0]    req1_cmd_in,
  input  logic [DW-1:0] req1_data_in,
  input  logic [1:0]    req1_tag_in,
  input  logic [3:0]    req2_cmd_in,
  input  logic [DW-1:0] req2_data_in,
  input  logic [1:0]    req2_tag_in,
  input  logic [3:0]    req3_cmd_in,
  input  logic [DW-1:0] req3_data_in,
  input  logic [1:0]    req3_tag_in,
  input  logic [3:0]    req4_cmd_in,
  input  logic [DW-1:0] req4_data_in,
  input  logic [1:0]    req4_tag_in,
  output logic [1:0]    out_resp1,
  output logic [DW-1:0] out_data1,
  output logic [1:0]    out_tag1,
  output logic [1:0]    out_resp2,
  output logic [DW-1:0] out_data2,
  output logic [1:0]    out_tag2,
  output logic [1:0]    out_resp3,
  output logic [DW-1:0] out_data3,
  output logic [1:0]    out_tag3,
  output logic [1:0]    out_resp4,
  output logic [DW-1:0] out_data4,
  output logic [1:0]    out_tag4,
  output logic          alu_valid,
  input  logic          alu_ready,
  output logic [3:0]    alu_cmd,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  output logic [3:0]    alu_id,
  input  logic          alu_rsp_valid,
  input  logic [3:0]    alu_rsp_id,
  input  logic [1:0]    alu_rsp_resp,
  input  logic [DW-1:0] alu_rsp_data
);

  logic [3:0]       cmd_a  [NPORT];
  logic [DW-1:0]    data_a [NPORT];
  logic [1:0]       tag_a  [NPORT];
  req_t             req_a  [NPORT];
  logic [1:0]       rej_resp_a [NPORT];
  logic [1:0]       rej_tag_a  [NPORT];
  logic [NPORT-1:0] pend, issue, rej_valid, rej_take;

  assign cmd_a  = '{req1_cmd_in,  req2_cmd_in,  req3_cmd_in,  req4_cmd_in};
  assign data_a = '{req1_data_in, req2_data_in, req3_data_in, req4_data_in};
  assign tag_a  = '{req1_tag_in,  req2_tag_in,  req3_tag_in,  req4_tag_in};

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    calc2_port_capture u_cap (
      .c_clk       (c_clk),
      .reset_n     (reset_n),
      .cmd_in      (cmd_a[p]),
      .data_in     (data_a[p]),
      .tag_in      (tag_a[p]),
      .issue_i     (issue[p]),
      .rej_take_i  (rej_take[p]),
      .pend_o      (pend[p]),
      .req_o       (req_a[p]),
      .rej_valid_o (rej_valid[p]),
      .rej_resp_o  (rej_resp_a[p]),
      .rej_tag_o   (rej_tag_a[p])
    );
  end

  logic [1:0] ptr_q, ptr_d, grant_q, pick, sel;
  logic       hold_q;
  logic [2:0] cnt_q, cnt_d;
  logic       hs, rsp_ok;
  logic [1:0] rsp_port;

  // ptr_q is the first port searched; lowest offset from it wins.
  always_comb begin
    pick = ptr_q;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (pend[ptr_q + 2'(i)]) pick = ptr_q + 2'(i);
    end
  end

  // A stalled offer keeps its grant so alu_* stay stable until accepted.
  assign sel       = hold_q ? grant_q : pick;
  assign alu_valid = (|pend) && (cnt_q < 3'(MAX_OUT));
  assign hs        = alu_valid && alu_ready;
  assign alu_cmd   = alu_valid ? req_a[sel].cmd : '0;
  assign alu_op1   = alu_valid ? req_a[sel].op1 : '0;
  assign alu_op2   = alu_valid ? req_a[sel].op2 : '0;
  assign alu_id    = alu_valid ? make_id(sel, req_a[sel].tag) : '0;
  assign ptr_d     = hs ? sel + 2'd1 : ptr_q;

  // A response with nothing outstanding is dropped entirely.
  assign rsp_ok   = alu_rsp_valid && (cnt_q != 3'd0);
  assign rsp_port = id_port(alu_rsp_id);

  always_comb begin
    cnt_d = cnt_q;
    if (hs && !rsp_ok)      cnt_d = cnt_q + 3'd1;
    else if (!hs && rsp_ok) cnt_d = cnt_q - 3'd1;
  end

  logic [1:0]    resp_q [NPORT], resp_d [NPORT];
  logic [DW-1:0] odat_q [NPORT], odat_d [NPORT];
  logic [1:0]    otag_q [NPORT], otag_d [NPORT];

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      issue[p] = hs && (sel == 2'(p));
      // ALU result wins the port's output slot; the reject waits a cycle.
      if (rsp_ok && (rsp_port == 2'(p))) begin
        rej_take[p] = 1'b0;
        resp_d[p]   = alu_rsp_resp;
        odat_d[p]   = alu_rsp_data;
        otag_d[p]   = id_tag(alu_rsp_id);
      end else if (rej_valid[p]) begin
        rej_take[p] = 1'b1;
        resp_d[p]   = rej_resp_a[p];
        odat_d[p]   = '0;
        otag_d[p]   = rej_tag_a[p];
      end else begin
        rej_take[p] = 1'b0;
        resp_d[p]   = RESP_NONE;
        odat_d[p]   = '0;
        otag_d[p]   = '0;
      end
    end
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      grant_q <= '0;
      hold_q  <= 1'b0;
      cnt_q   <= '0;
      for (int p = 0; p < NPORT; p++) begin
        resp_q[p] <= '0;
        odat_q[p] <= '0;
        otag_q[p] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= sel;
      hold_q  <= alu_valid && !alu_ready;
      cnt_q   <= cnt_d;
      for (int p = 0; p < NPORT; p++) begin
        resp_q[p] <= resp_d[p];
        odat_q[p] <= odat_d[p];
        otag_q[p] <= otag_d[p];
      end
    end
  end

  assign out_resp1 = resp_q[0];
  assign out_data1 = odat_q[0];
  assign out_tag1  = otag_q[0];
  assign out_resp2 = resp_q[1];
  assign out_data2 = odat_q[1];
  assign out_tag2  = otag_q[1];
  assign out_resp3 = resp_q[2];
  assign out_data3 = odat_q[2];
  assign out_tag3  = otag_q[2];
  assign out_resp4 = resp_q[3];
  assign out_data4 = odat_q[3];
  assign out_tag4  = otag_q[3];

  a_rsp_needs_outstanding: assert property (
    @(posedge c_clk) disable iff (!reset_n) !(alu_rsp_valid && (cnt_q == 3'd0)));

  a_cnt_bounded: assert property (
    @(posedge c_clk) disable iff (!reset_n) cnt_q <= 3'(MAX_OUT));

endmodule

// File: tb/tb_calc2_req_arbiter.sv
module tb_calc2_req_arbiter;

  logic        c_clk;
  logic        reset_n;
  logic [3:0]  cmd_i [4];
  logic [31:0] dat_i [4];
  logic [1:0]  tg_i  [4];
  logic [1:0]  o_resp [4];
  logic [31:0] o_data [4];
  logic [1:0]  o_tag  [4];
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_cmd, alu_id;
  logic [31:0] alu_op1, alu_op2;
  logic        alu_rsp_valid;
  logic [3:0]  alu_rsp_id;
  logic [1:0]  alu_rsp_resp;
  logic [31:0] alu_rsp_data;

  int n_assert = 0;
  int n_fail   = 0;

  calc2_req_arbiter dut (
    .c_clk(c_clk), .reset_n(reset_n),
    .req1_cmd_in(cmd_i[0]), .req1_data_in(dat_i[0]), .req1_tag_in(tg_i[0]),
    .req2_cmd_in(cmd_i[1]), .req2_data_in(dat_i[1]), .req2_tag_in(tg_i[1]),
    .req3_cmd_in(cmd_i[2]), .req3_data_in(dat_i[2]), .req3_tag_in(tg_i[2]),
    .req4_cmd_in(cmd_i[3]), .req4_data_in(dat_i[3]), .req4_tag_in(tg_i[3]),
    .out_resp1(o_resp[0]), .out_data1(o_data[0]), .out_tag1(o_tag[0]),
    .out_resp2(o_resp[1]), .out_data2(o_data[1]), .out_tag2(o_tag[1]),
    .out_resp3(o_resp[2]), .out_data3(o_data[2]), .out_tag3(o_tag[2]),
    .out_resp4(o_resp[3]), .out_data4(o_data[3]), .out_tag4(o_tag[3]),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_cmd(alu_cmd),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_id(alu_id),
    .alu_rsp_valid(alu_rsp_valid), .alu_rsp_id(alu_rsp_id),
    .alu_rsp_resp(alu_rsp_resp), .alu_rsp_data(alu_rsp_data)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge c_clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [3:0] c, input logic [31:0] d, input logic [1:0] t);
    cmd_i[p] = c;
    dat_i[p] = d;
    tg_i[p]  = t;
  endtask

  task automatic idle_all();
    for (int p = 0; p < 4; p++) drive(p, 4'd0, 32'd0, 2'd0);
  endtask

  task automatic rsp(input logic [3:0] id, input logic [1:0] r, input logic [31:0] d);
    alu_rsp_valid = 1'b1;
    alu_rsp_id    = id;
    alu_rsp_resp  = r;
    alu_rsp_data  = d;
  endtask

  task automatic rsp_off();
    alu_rsp_valid = 1'b0;
    alu_rsp_id    = 4'd0;
    alu_rsp_resp  = 2'd0;
    alu_rsp_data  = 32'd0;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    alu_ready = 1'b0;
    idle_all();
    rsp_off();
    #2;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    alu_ready = 1'b0;
    idle_all();
    rsp_off();
    #2;
    cyc();
    // reset state
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_alu_id", alu_id, 0);
    chk("rst_resp1", o_resp[0], 0);
    chk("rst_resp4", o_resp[3], 0);
    chk("rst_data2", o_data[1], 0);
    cyc();
    reset_n = 1'b1;

    // 1: single add on port 1
    drive(0, 4'd1, 32'h30, 2'd1);
    cyc();
    drive(0, 4'd0, 32'h20, 2'd0);
    chk("t1_op2_cycle_valid", alu_valid, 0);
    cyc();
    drive(0, 4'd0, 32'h0, 2'd0);
    chk("t1_valid", alu_valid, 1);
    chk("t1_id", alu_id, 4'h1);
    chk("t1_cmd", alu_cmd, 4'd1);
    chk("t1_op1", alu_op1, 32'h30);
    chk("t1_op2", alu_op2, 32'h20);
    alu_ready = 1'b1;
    cyc();
    alu_ready = 1'b0;
    chk("t1_valid_after_issue", alu_valid, 0);
    rsp(4'h1, 2'd1, 32'h50);
    cyc();
    rsp_off();
    chk("t1_resp1", o_resp[0], 1);
    chk("t1_data1", o_data[0], 32'h50);
    chk("t1_tag1", o_tag[0], 1);
    chk("t1_resp2_quiet", o_resp[1], 0);
    cyc();
    chk("t1_resp1_oneshot", o_resp[0], 0);
    chk("t1_data1_oneshot", o_data[0], 0);

    // 2: all four ports at once, round robin order, out-of-order responses
    do_reset();
    for (int p = 0; p < 4; p++) drive(p, 4'd1, 32'h100 + p, 2'(p));
    cyc();
    for (int p = 0; p < 4; p++) drive(p, 4'd0, 32'h200 + p, 2'd0);
    cyc();
    idle_all();
    chk("t2_id_p1", alu_id, 4'h0);
    chk("t2_op1_p1", alu_op1, 32'h100);
    chk("t2_op2_p1", alu_op2, 32'h200);
    alu_ready = 1'b1;
    cyc();
    chk("t2_id_p2", alu_id, 4'h5);
    chk("t2_op1_p2", alu_op1, 32'h101);
    cyc();
    chk("t2_id_p3", alu_id, 4'hA);
    cyc();
    chk("t2_id_p4", alu_id, 4'hF);
    chk("t2_op2_p4", alu_op2, 32'h203);
    cyc();
    alu_ready = 1'b0;
    chk("t2_drained", alu_valid, 0);
    rsp(4'hF, 2'd1, 32'hAAA);
    cyc();
    chk("t2_resp4", o_resp[3], 1);
    chk("t2_tag4", o_tag[3], 3);
    chk("t2_data4", o_data[3], 32'hAAA);
    rsp(4'h5, 2'd2, 32'h0);
    cyc();
    chk("t2_resp2_ovf", o_resp[1], 2);
    chk("t2_tag2", o_tag[1], 1);
    chk("t2_resp4_cleared", o_resp[3], 0);
    rsp(4'h0, 2'd1, 32'h123);
    cyc();
    chk("t2_resp1", o_resp[0], 1);
    chk("t2_data1", o_data[0], 32'h123);
    rsp(4'hA, 2'd1, 32'h456);
    cyc();
    rsp_off();
    chk("t2_resp3", o_resp[2], 1);
    chk("t2_tag3", o_tag[2], 2);
    chk("t2_data3", o_data[2], 32'h456);
    drive(1, 4'd2, 32'h7, 2'd0);
    drive(0, 4'd2, 32'h9, 2'd3);
    cyc();
    drive(1, 4'd0, 32'h1, 2'd0);
    drive(0, 4'd0, 32'h1, 2'd0);
    cyc();
    idle_all();
    chk("t2_round2_first", alu_id, 4'h3);
    chk("t2_round2_cmd", alu_cmd, 4'd2);
    alu_ready = 1'b1;
    cyc();
    chk("t2_round2_second", alu_id, 4'h4);
    cyc();
    alu_ready = 1'b0;
    chk("t2_round2_done", alu_valid, 0);

    // 3: busy reject while port 2 stalls; grant held against a new pending port
    do_reset();
    drive(1, 4'd1, 32'h11, 2'd1);
    cyc();
    drive(1, 4'd0, 32'h22, 2'd0);
    cyc();
    chk("t3_id", alu_id, 4'h5);
    drive(1, 4'd2, 32'h99, 2'd3);
    drive(0, 4'd1, 32'h55, 2'd2);
    cyc();
    drive(1, 4'd0, 32'h77, 2'd0);
    drive(0, 4'd0, 32'h66, 2'd0);
    chk("t3_hold_op1", alu_op1, 32'h11);
    chk("t3_resp2_not_yet", o_resp[1], 0);
    cyc();
    idle_all();
    chk("t3_busy_resp2", o_resp[1], 3);
    chk("t3_busy_tag2", o_tag[1], 3);
    chk("t3_busy_data2", o_data[1], 0);
    chk("t3_hold_id", alu_id, 4'h5);
    chk("t3_hold_cmd", alu_cmd, 4'd1);
    chk("t3_hold_op2", alu_op2, 32'h22);
    alu_ready = 1'b1;
    cyc();
    chk("t3_busy_oneshot", o_resp[1], 0);
    chk("t3_next_valid", alu_valid, 1);
    chk("t3_next_id", alu_id, 4'h2);
    chk("t3_next_op1", alu_op1, 32'h55);
    chk("t3_next_op2", alu_op2, 32'h66);
    cyc();
    alu_ready = 1'b0;
    chk("t3_done", alu_valid, 0);

    // 4: invalid command on port 3
    do_reset();
    drive(2, 4'h3, 32'h5, 2'd2);
    cyc();
    drive(2, 4'd0, 32'h6, 2'd0);
    chk("t4_no_valid_a", alu_valid, 0);
    cyc();
    idle_all();
    chk("t4_no_valid_b", alu_valid, 0);
    cyc();
    chk("t4_no_valid_c", alu_valid, 0);
    chk("t4_resp3", o_resp[2], 2);
    chk("t4_tag3", o_tag[2], 2);
    chk("t4_data3", o_data[2], 0);
    cyc();
    chk("t4_resp3_oneshot", o_resp[2], 0);

    // 5: in-flight limit
    do_reset();
    for (int p = 0; p < 4; p++) drive(p, 4'd1, 32'h300 + p, 2'd0);
    cyc();
    for (int p = 0; p < 4; p++) drive(p, 4'd0, 32'h400 + p, 2'd0);
    cyc();
    idle_all();
    chk("t5_first_id", alu_id, 4'h0);
    alu_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("t5_fourth_id", alu_id, 4'hC);
    drive(3, 4'd1, 32'h44, 2'd1);
    cyc();
    drive(3, 4'd0, 32'h45, 2'd0);
    chk("t5_full_a", alu_valid, 0);
    cyc();
    idle_all();
    chk("t5_full_pending", alu_valid, 0);
    rsp(4'h0, 2'd1, 32'h1);
    cyc();
    rsp(4'h4, 2'd1, 32'h77);
    chk("t5_resume_valid", alu_valid, 1);
    chk("t5_resume_id", alu_id, 4'hD);
    chk("t5_resume_op1", alu_op1, 32'h44);
    chk("t5_resume_op2", alu_op2, 32'h45);
    chk("t5_resp1", o_resp[0], 1);
    cyc();
    rsp_off();
    alu_ready = 1'b0;
    chk("t5_resp2", o_resp[1], 1);
    chk("t5_data2", o_data[1], 32'h77);

    // 6: asynchronous reset with requests in flight
    reset_n = 1'b0;
    #1;
    chk("t6_async_resp2", o_resp[1], 0);
    chk("t6_async_data2", o_data[1], 0);
    chk("t6_async_valid", alu_valid, 0);
    do_reset();
    drive(0, 4'd2, 32'h10, 2'd2);
    cyc();
    drive(0, 4'd0, 32'h3, 2'd0);
    cyc();
    idle_all();
    chk("t6_post_valid", alu_valid, 1);
    chk("t6_post_id", alu_id, 4'h2);
    chk("t6_post_cmd", alu_cmd, 4'd2);
    alu_ready = 1'b1;
    cyc();
    alu_ready = 1'b0;
    rsp(4'h2, 2'd1, 32'hD);
    cyc();
    rsp_off();
    chk("t6_post_resp1", o_resp[0], 1);
    chk("t6_post_data1", o_data[0], 32'hD);
    chk("t6_post_tag1", o_tag[0], 2);
    cyc();
    chk("t6_post_oneshot", o_resp[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
